// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the dual-lane data-memory responder
package dmem_pkg;
  localparam int WORD_W = 32;
  localparam int DEPTH_DEF = 256;
  localparam int IDX_W_DEF = $clog2(DEPTH_DEF);
  typedef enum logic {IDLE, SERVE2} state_t;
  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } req_t;
  function automatic logic misaligned(input logic [WORD_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM, write and registered read share one index
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) r_mem[idx] <= wdata;
    rdata <= r_mem[idx];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: serialises two request lanes onto one single-port array.
// Define DMEM_MISALIGN_TRAP_EN to suppress and flag accesses with addr[1:0]!=0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [WORD_W-1:0] req1_addr,
  input  logic [WORD_W-1:0] req1_wdata,
  input  logic              req2_valid,
  input  logic              req2_we,
  input  logic [WORD_W-1:0] req2_addr,
  input  logic [WORD_W-1:0] req2_wdata,
  output logic              req_ready,
  output logic              rsp1_valid,
  output logic [WORD_W-1:0] rsp1_rdata,
  output logic              rsp2_valid,
  output logic [WORD_W-1:0] rsp2_rdata,
  output logic [1:0]        rsp_err,
  output logic              stall
);
  state_t            r_state, w_next;
  req_t              r_hold, w_sel;
  logic              w_go, w_lane2, w_capture, w_mis, w_we;
  logic              r_v1, r_v2, r_ld;
  logic [1:0]        r_err;
  logic [WORD_W-1:0] r_last1, r_last2, w_mem_rdata, w_out;
  always_comb begin
    w_next    = IDLE;
    w_sel     = r_hold;
    w_lane2   = 1'b1;
    w_go      = 1'b1;
    w_capture = 1'b0;
    if (r_state == IDLE) begin
      w_go      = req1_valid | req2_valid;
      w_lane2   = !req1_valid;
      w_sel     = req1_valid ? req_t'{req1_we, req1_addr, req1_wdata}
                             : req_t'{req2_we, req2_addr, req2_wdata};
      w_capture = req1_valid & req2_valid;
      w_next    = w_capture ? SERVE2 : IDLE;
    end
  end
`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_mis = misaligned(w_sel.addr);
`else
  assign w_mis = 1'b0;
`endif
  // reset gates the write so a discarded held store never reaches the array
  assign w_we  = w_go & w_sel.we & !w_mis & !reset;
  assign w_out = r_ld ? w_mem_rdata : '0;
  dmem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .we    (w_we),
    .idx   (w_sel.addr[IDX_W+1:2]),
    .wdata (w_sel.wdata),
    .rdata (w_mem_rdata)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_ld    <= 1'b0;
      r_err   <= 2'b00;
      r_last1 <= '0;
      r_last2 <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture) r_hold <= req_t'{req2_we, req2_addr, req2_wdata};
      r_v1    <= w_go & !w_lane2;
      r_v2    <= w_go & w_lane2;
      r_ld    <= !w_sel.we & !w_mis;
      r_err   <= {w_go & w_lane2 & w_mis, w_go & !w_lane2 & w_mis};
      if (r_v1) r_last1 <= w_out;
      if (r_v2) r_last2 <= w_out;
    end
  end
  assign req_ready  = r_state == IDLE;
  assign stall      = r_state == SERVE2;
  assign rsp1_valid = r_v1;
  assign rsp2_valid = r_v2;
  assign rsp1_rdata = r_v1 ? w_out : r_last1;
  assign rsp2_rdata = r_v2 ? w_out : r_last2;
  assign rsp_err    = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector table, hand sequences and random traffic against a word-array model
module tb_dmem_responder;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req1_valid = 0, req1_we = 0, req2_valid = 0, req2_we = 0;
  logic [31:0] req1_addr = 0, req1_wdata = 0, req2_addr = 0, req2_wdata = 0;
  logic        req_ready, rsp1_valid, rsp2_valid, stall;
  logic [31:0] rsp1_rdata, rsp2_rdata;
  logic [1:0]  rsp_err;
  int checks = 0, failures = 0;
  logic [31:0] m [256];

  typedef struct {
    logic v1, w1; logic [31:0] a1, d1;
    logic v2, w2; logic [31:0] a2, d2;
    logic [31:0] e1, e2;
  } vec_t;
  vec_t tbl [9];

  dmem_responder dut (
    .clk(clk), .reset(reset),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req2_valid(req2_valid), .req2_we(req2_we), .req2_addr(req2_addr), .req2_wdata(req2_wdata),
    .req_ready(req_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .rsp2_valid(rsp2_valid), .rsp2_rdata(rsp2_rdata), .rsp_err(rsp_err), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req1_valid = v.v1; req1_we = v.w1; req1_addr = v.a1; req1_wdata = v.d1;
    req2_valid = v.v2; req2_we = v.w2; req2_addr = v.a2; req2_wdata = v.d2;
  endtask

  task automatic idle_in();
    req1_valid = 0; req2_valid = 0;
  endtask

  // program-order model: lane 1 acts before lane 2 on a plain word array
  function automatic void model(input vec_t v, output logic [31:0] e1, output logic [31:0] e2);
    e1 = 0; e2 = 0;
    if (v.v1) begin
      if (v.w1) m[v.a1[9:2]] = v.d1; else e1 = m[v.a1[9:2]];
    end
    if (v.v2) begin
      if (v.w2) m[v.a2[9:2]] = v.d2; else e2 = m[v.a2[9:2]];
    end
  endfunction

  task automatic txn(input vec_t v, input logic [31:0] e1, input logic [31:0] e2);
    logic dual;
    dual = v.v1 && v.v2;
    drive(v);
    @(posedge clk); #1; idle_in();
    chk("ready", req_ready, !dual);
    chk("stall", stall, dual);
    chk("rsp1_v", rsp1_valid, v.v1);
    chk("rsp2_v", rsp2_valid, v.v2 && !dual);
    chk("err", rsp_err, 0);
    if (v.v1) chk("rsp1_d", rsp1_rdata, e1);
    if (v.v2 && !dual) chk("rsp2_d", rsp2_rdata, e2);
    if (dual) begin
      @(posedge clk); #1;
      chk("rsp2_v_late", rsp2_valid, 1);
      chk("rsp1_v_late", rsp1_valid, 0);
      chk("rsp2_d_late", rsp2_rdata, e2);
      chk("ready_late", req_ready, 1);
      chk("stall_late", stall, 0);
    end
    @(posedge clk); #1;
    chk("idle_v", {30'd0, rsp1_valid, rsp2_valid}, 0);
    if (v.v2) chk("rsp2_hold", rsp2_rdata, e2);
    else chk("rsp1_hold", rsp1_rdata, e1);
  endtask

  initial begin
    vec_t v;
    logic [31:0] e1, e2, d;
    logic [1:0] exp_err;
    for (int i = 0; i < 256; i++) m[i] = 0;
    tbl[0] = '{1,1,32'h10,32'hDEADBEEF, 0,0,0,0,                 0,0};
    tbl[1] = '{1,0,32'h10,0,            0,0,0,0,                 32'hDEADBEEF,0};
    tbl[2] = '{1,1,32'h20,32'h11111111, 1,0,32'h20,0,            0,32'h11111111};
    tbl[3] = '{1,1,32'h40,32'hAAAA0000, 1,1,32'h40,32'h5555FFFF, 0,0};
    tbl[4] = '{1,0,32'h40,0,            0,0,0,0,                 32'h5555FFFF,0};
    tbl[5] = '{1,1,32'h0,32'h12345678,  0,0,0,0,                 0,0};
    tbl[6] = '{0,0,0,0,                 1,0,32'h400,0,           0,32'h12345678};
    tbl[7] = '{1,0,32'h20,0,            1,1,32'h20,32'h22222222, 32'h11111111,0};
    tbl[8] = '{0,0,0,0,                 1,0,32'h20,0,            0,32'h22222222};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_valid", {30'd0, rsp1_valid, rsp2_valid}, 0);
    chk("rst_rdata1", rsp1_rdata, 0);
    chk("rst_rdata2", rsp2_rdata, 0);
    chk("rst_err", rsp_err, 0);
    reset = 0;

    for (int i = 0; i < 9; i++) begin
      model(tbl[i], e1, e2);
      txn(tbl[i], tbl[i].e1, tbl[i].e2);
    end

    // misaligned lane-2 store to 0x13 and lane-1 load from 0x11
    v = '{0,0,0,0, 1,1,32'h13,32'h99999999, 0,0};
    drive(v);
    @(posedge clk); #1; idle_in();
`ifdef DMEM_MISALIGN_TRAP_EN
    exp_err = 2'b10;
`else
    exp_err = 2'b00;
    m[4] = 32'h99999999;
`endif
    chk("mis_st_v", rsp2_valid, 1);
    chk("mis_st_err", rsp_err, exp_err);
    v = '{1,0,32'h11,0, 0,0,0,0, 0,0};
    drive(v);
    @(posedge clk); #1; idle_in();
    chk("mis_ld_v", rsp1_valid, 1);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("mis_ld_err", rsp_err, 2'b01);
    chk("mis_ld_d", rsp1_rdata, 0);
`else
    chk("mis_ld_err", rsp_err, 0);
    chk("mis_ld_d", rsp1_rdata, m[4]);
`endif
    v = '{1,0,32'h10,0, 0,0,0,0, 0,0};
    model(v, e1, e2);
    txn(v, e1, e2);

    // reset while the held lane-2 store is pending
    v = '{1,1,32'h80,32'hCAFE0001, 0,0,0,0, 0,0};
    model(v, e1, e2);
    txn(v, e1, e2);
    v = '{1,1,32'h84,32'h00000001, 1,1,32'h80,32'h00000BAD, 0,0};
    drive(v);
    @(posedge clk); #1; idle_in();
    m[33] = 32'h00000001;
    chk("mid_stall", stall, 1);
    chk("mid_ready", req_ready, 0);
    chk("mid_rsp1_v", rsp1_valid, 1);
    reset = 1;
    #1;
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_rdata1", rsp1_rdata, 0);
    @(posedge clk); #1;
    chk("mid_rst_rsp2_v", rsp2_valid, 0);
    reset = 0;
    @(posedge clk); #1;
    chk("post_rst_rsp2_v", rsp2_valid, 0);
    v = '{0,0,0,0, 1,0,32'h80,0, 0,0};
    model(v, e1, e2);
    txn(v, e1, e2);
    v = '{1,0,32'h84,0, 0,0,0,0, 0,0};
    model(v, e1, e2);
    txn(v, e1, e2);

    // random traffic over 8 words with random upper address bits
    for (int i = 0; i < 8; i++) begin
      v = '{1,1,($urandom & 32'hFFFFFC00) | 32'(i << 2),$urandom, 0,0,0,0, 0,0};
      model(v, e1, e2);
      txn(v, e1, e2);
    end
    for (int i = 0; i < 200; i++) begin
      d = $urandom;
      v.v1 = d[0]; v.v2 = d[1] | !d[0];
      v.w1 = d[2]; v.w2 = d[3];
      v.a1 = ($urandom & 32'hFFFFFC00) | (32'($urandom_range(0, 7)) << 2);
      v.a2 = ($urandom & 32'hFFFFFC00) | (32'($urandom_range(0, 7)) << 2);
      v.d1 = $urandom; v.d2 = $urandom;
      model(v, e1, e2);
      txn(v, e1, e2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Responder end of the core's dual-lane data-memory interface. Accepts load/store requests from the EX/MEM stage of both issue lanes and serialises them onto one single-port word array. Returns read data one cycle after service. Drives a stall back to the hazard logic while a second-lane request is pending. Replaces the combinational dual-port data memory with a realistic single-port responder.

Parameters:
DEPTH, 256, number of 32-bit words in the array (power of two)
IDX_W, 8, word-index width, equal to log2(DEPTH)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req1_valid  in  1  lane-1 request present (lane 1 is older in program order)
req1_we  in  1  lane-1 store (1) / load (0)
req1_addr  in  32  lane-1 byte address
req1_wdata  in  32  lane-1 store data
req2_valid  in  1  lane-2 request present
req2_we  in  1  lane-2 store / load
req2_addr  in  32  lane-2 byte address
req2_wdata  in  32  lane-2 store data
req_ready  out  1  both lanes may present requests this cycle
rsp1_valid  out  1  lane-1 response (load data or store ack)
rsp1_rdata  out  32  lane-1 load data, 0 for stores
rsp2_valid  out  1  lane-2 response
rsp2_rdata  out  32  lane-2 load data, 0 for stores
rsp_err  out  2  per-lane misalign flag, bit0 = lane 1, bit1 = lane 2 (only with optional feature, else tied 0)
stall  out  1  responder busy; core must hold the EX/MEM latch

Behaviour:
- Reset values: state IDLE; req_ready=1; rsp1_valid=0, rsp2_valid=0; rdata=0; rsp_err=0; stall=0; hold register cleared. Array contents are not cleared.
- Index: idx = addr[IDX_W+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH words.
- The array performs one access per cycle. A read returns registered data on the next edge.
- A request is accepted on a cycle where its valid is high and req_ready is high.
- req_ready = (state==IDLE). stall = (state==SERVE2).
- FSM states:
  - IDLE, only req1 valid: service lane 1. rsp1_valid=1 next cycle. Stay IDLE.
  - IDLE, only req2 valid: service lane 2 directly. rsp2_valid=1 next cycle. Stay IDLE.
  - IDLE, both valid: service lane 1, capture lane 2 into the hold register, go to SERVE2.
  - SERVE2: service the hold register. rsp2_valid=1 next cycle. Return to IDLE. Inputs are ignored in this state.
- Latency: 1 cycle for a single-lane request. For dual requests, lane 1 responds at +1 and lane 2 at +2.
- Ordering rules:
  - Lane 1 store then lane 2 load to the same index: lane 2 reads the new data.
  - Both lanes store to the same index: the lane-2 value remains.
  - Lane 1 load and lane 2 store to the same index: lane 1 reads the old data.
- Responses are one-cycle pulses with no backpressure. rdata holds its last value when valid is low.
- Reset asserted mid-operation (in SERVE2): the held request is discarded, no write occurs, no response is issued, and the FSM goes to IDLE immediately.

Optional Feature:
DMEM_MISALIGN_TRAP_EN
- Defined: when addr[1:0]!=0, the access is flagged. A flagged store is suppressed (array unchanged). A flagged load returns 0. The response still pulses, with the matching rsp_err bit high in the same cycle as rspN_valid.
- Undefined: addr[1:0] is ignored (word access at idx) and rsp_err is tied 0.

Decomposition:
- Package dmem_pkg: FSM state enum {IDLE, SERVE2}, WORD_W=32, the request struct (we, addr, wdata), and the localparam relation IDX_W = $clog2(DEPTH).
- Sub-module dmem_array: single-port synchronous RAM with clk, we, idx, wdata, rdata and a registered read, no reset.
- The FSM, arbitration and response steering stay in dmem_responder.

Test Plan:
- Lane 1 store 0xDEADBEEF to addr 0x10, then lane 1 load 0x10 -> rsp1_valid pulse for the store ack; the next load gives rsp1_rdata=0xDEADBEEF one cycle after acceptance.
- Same cycle: lane 1 store 0x11111111 and lane 2 load, both to 0x20 -> stall=1 and req_ready=0 for exactly 1 cycle; rsp1 at +1; rsp2_rdata=0x11111111 at +2.
- Same cycle: both lanes store to 0x40 (0xAAAA0000 from lane 1, 0x5555FFFF from lane 2), then load 0x40 -> 0x5555FFFF.
- Store 0x12345678 to 0x0, then load 4*DEPTH (0x400 with DEPTH=256) -> 0x12345678 (wrap-around).
- Dual request, then reset asserted while stall=1 -> no rsp2_valid, lane-2 store not committed (later load of that address returns the prior value), req_ready=1 immediately.
- With DMEM_MISALIGN_TRAP_EN defined: lane 2 store to 0x13 -> rsp_err=2'b10 with rsp2_valid; a following load of 0x10 shows the array unchanged.
